uart_rx_ovs: RTL and testbench
==============================

# uart_rx_ovs

Parametrised UART receiver for the 16550-class serial core: deserialises 5–8 data bits with optional (sticky) parity. Compared with the base receiver it adds:
- a configurable oversampling ratio;
- a two-flop input synchroniser;
- majority-of-3 mid-bit sampling;
- per-frame configuration latching;
- true break detection with wait-for-mark recovery.

Frames are delivered as a single-cycle `push` strobe to the RX FIFO.

## Interface
Parameters:
- `OVS`, 16: baud_pulse ticks per bit; legal values 8 or 16. M = OVS/2.
- `CW`, $clog2(OVS): tick counter width (derived; do not override).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `baud_pulse` in 1: one-clk-wide tick at OVS × baud rate.
- `rx` in 1: asynchronous serial input, idle high.
- `wls` in 2: word length select, 00=5 … 11=8 data bits.
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sticky_parity` in 1: stick parity.
- `push` out 1: one-clk strobe, frame complete.
- `dout` out 8: received data, right-aligned, unused MSBs zero.
- `pe` out 1: parity error.
- `fe` out 1: framing error.
- `bi` out 1: break indication.

## Operation
- **Synchroniser**: rx passes through two flops reset to 1, producing rx_s. All decisions use rx_s.
- **Tick counter**: cnt advances only on baud_pulse. Clocks without baud_pulse hold all state.
- **Majority sampling**:
  - The pulses at cnt = M-1, M and M+1 capture rx_s into a 3-bit window.
  - The bit value is the majority of the window, evaluated on the cnt = M+1 pulse.
- **Configuration latching**: wls, pen, eps and sticky_parity are latched on the IDLE→START transition. Changes mid-frame affect only the next frame.
- **States**: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- **IDLE**: on a baud_pulse with rx_s=0, go to START with cnt=0 and latch the configuration.
- **START**:
  - At the mid decision, majority=1 means a false start: return to IDLE and push nothing.
  - Otherwise, on cnt=OVS-1 go to DATA with cnt=0 and bitcnt=0.
- **DATA**:
  - At the mid decision, shift the bit in LSB-first into a right-aligned shift register of n = 5 + wls bits.
  - On cnt=OVS-1: if bitcnt=n-1, go to PARITY if pen else STOP; otherwise increment bitcnt.
- **PARITY**: at the mid decision capture parity bit p. The expected value is:
  - sticky=1: ~eps.
  - sticky=0, eps=1: even; XOR of data and p must be 0.
  - sticky=0, eps=0: odd; XOR of data and p must be 1.
  - On cnt=OVS-1 go to STOP.
- **STOP**: at the mid decision, on the cnt = M+1 pulse:
  - fe = ~bit.
  - pe = parity mismatch, or 0 if pen=0.
  - bi = 1 iff data=0, parity bit=0 (when pen) and stop bit=0.
  - Load dout, pulse push, then go to BRK_WAIT if bi else IDLE. The remaining half stop bit is not waited for, so back-to-back frames resynchronise early.
- **BRK_WAIT**: stay until a baud_pulse sees rx_s=1, then go to IDLE. A continuous break yields exactly one push.
- **Status hold**: dout, pe, fe and bi are updated only at push and hold until the next push.
- **Two stop bits**: only the first stop bit is checked.

## Timing
- **Reset values**:
  - push, pe, fe, bi = 0; dout = 0.
  - State IDLE, cnt = 0, bitcnt = 0, synchroniser flops = 1.
  - Reset mid-frame aborts the frame with no push.
- **Input latency**: 2 clk from rx to rx_s.
- **Frame latency**: push occurs on the baud_pulse that is OVS·(1+n+pen) + M+1 pulses after the start-detect pulse, counting the start-detect pulse as pulse 0. For OVS=16, 8N1 this is 153.
- **push timing**: registered; high in the clk cycle after that baud_pulse edge, for exactly 1 clk.
- **Output alignment**: dout, pe, fe and bi are valid in the same cycle as push.
- **Simultaneous events**: rst dominates baud_pulse. An rx edge coincident with baud_pulse is seen by IDLE only after the 2-clk synchroniser.

## Test plan
- **8N1 frame**: OVS=16, wls=11, pen=0, send 0xA5 with stop=1 → one push after 153 pulses; dout=0xA5, pe=fe=bi=0.
- **7E1 parity error**: wls=10, pen=1, eps=1, send 0x35 with parity bit 1 (expected 0) → push, dout=0x35, pe=1, fe=0.
- **False start and glitch rejection**:
  - rx low for 4 ticks only → no push, state returns to IDLE.
  - A separate 0x00 frame with a 1-tick high glitch at cnt=M in bit 3 → dout=0x00.
- **Break**: hold rx low for 3 frame times, pen=1 → exactly one push with dout=0, bi=1, fe=1. No further push until rx goes high; the next valid frame 0x5A is then received correctly.
- **OVS=8 instance**: wls=00, sticky_parity=1, eps=0, send 0x1F with parity bit 1, back-to-back with a second frame 0x0A → two pushes; dout=0x1F then 0x0A, pe=0 on both.
- **Config change and reset mid-frame**: changing wls mid-frame does not alter the current frame. Asserting rst in DATA gives no push, all outputs 0, and the next frame is received normally.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with majority voting, per-frame config latch and break handling
// Ports: clk, rst (sync, active-high); baud_pulse = one tick, OVS ticks per bit; rx = async serial input;
// wls/pen/eps/sticky_parity = frame format, latched at start detect; push strobes dout/pe/fe/bi, held until next push.
module uart_rx_ovs #(
  parameter int OVS = 16,
  parameter int CW = $clog2(OVS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi
);
  localparam logic [CW-1:0] MID = CW'(OVS / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state, state_n;
  logic [1:0] sync, win, wls_l;
  logic [CW-1:0] cnt, nc;
  logic [2:0] bitcnt, top;
  logic [7:0] sh;
  logic rx_s, pen_l, eps_l, sp_l, par, maj, mid, last, perr, brk;
  assign rx_s = sync[1];
  // cnt is the in-bit position of the previous pulse, nc that of the current one; the start-detect pulse is position 0
  assign nc = cnt + 1'b1;
  assign mid = baud_pulse && nc == MID;
  assign last = baud_pulse && nc == LAST;
  // win holds the two previous samples, so on the MID pulse the vote covers positions M-1..M+1
  assign maj = (win[1] & win[0]) | (win[1] & rx_s) | (win[0] & rx_s);
  assign top = 3'd4 + {1'b0, wls_l};
  // sticky parity expects ~eps; otherwise data^p must equal ~eps (0 for even, 1 for odd)
  assign perr = (sp_l ? 1'b0 : ^sh) ^ par ^ ~eps_l;
  assign brk = sh == 8'd0 && !(pen_l && par) && !maj;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = baud_pulse && !rx_s ? START : IDLE;
      START:    state_n = mid && maj ? IDLE : last ? DATA : START;
      DATA:     state_n = last && bitcnt == top ? (pen_l ? PARITY : STOP) : DATA;
      PARITY:   state_n = last ? STOP : PARITY;
      STOP:     state_n = mid ? (brk ? BRK_WAIT : IDLE) : STOP;
      BRK_WAIT: state_n = baud_pulse && rx_s ? IDLE : BRK_WAIT;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      win <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bitcnt <= '0;
      sh <= '0;
      wls_l <= '0;
      pen_l <= 1'b0;
      eps_l <= 1'b0;
      sp_l <= 1'b0;
      par <= 1'b0;
      push <= 1'b0;
      dout <= '0;
      pe <= 1'b0;
      fe <= 1'b0;
      bi <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      state <= state_n;
      push <= 1'b0;
      if (baud_pulse) begin
        win <= {win[0], rx_s};
        cnt <= state == IDLE || state_n == IDLE ? '0 : nc;
      end
      if (state == IDLE && state_n == START) begin
        wls_l <= wls;
        pen_l <= pen;
        eps_l <= eps;
        sp_l <= sticky_parity;
        bitcnt <= '0;
        sh <= '0;
        par <= 1'b0;
      end
      // bits enter at position n-1 and shift right, leaving the frame right-aligned LSB-first
      if (state == DATA && mid) sh <= (sh >> 1) | (8'(maj) << top);
      if (state == DATA && last) bitcnt <= bitcnt == top ? '0 : bitcnt + 1'b1;
      if (state == PARITY && mid) par <= maj;
      // the frame is delivered mid stop bit so back-to-back frames resynchronise early
      if (state == STOP && mid) begin
        push <= 1'b1;
        dout <= sh;
        pe <= pen_l & perr;
        fe <= ~maj;
        bi <= brk;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: scoreboard bench for uart_rx_ovs with OVS=16 and OVS=8 instances
module tb_uart_rx_ovs;
  typedef struct packed {logic [7:0] d; logic pe; logic fe; logic bi;} exp_t;
  logic clk = 0, rst = 1, baud_pulse = 0, rx16 = 1, rx8 = 1, pen = 0, eps = 0, sticky_parity = 0;
  logic [1:0] wls = 2'b11;
  logic push16, pe16, fe16, bi16, push8, pe8, fe8, bi8;
  logic [7:0] dout16, dout8;
  int checks = 0, fails = 0, tick = 0, t_start = 0, np16 = 0, np8 = 0, last16 = 0;
  exp_t q16[$], q8[$], e16, e8;
  uart_rx_ovs #(.OVS(16)) dut16 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx16), .wls(wls), .pen(pen), .eps(eps),
    .sticky_parity(sticky_parity), .push(push16), .dout(dout16), .pe(pe16), .fe(fe16), .bi(bi16)
  );
  uart_rx_ovs #(.OVS(8)) dut8 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx8), .wls(wls), .pen(pen), .eps(eps),
    .sticky_parity(sticky_parity), .push(push8), .dout(dout8), .pe(pe8), .fe(fe8), .bi(bi8)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (3) @(negedge clk);
    baud_pulse = 1;
    @(negedge clk);
    baud_pulse = 0;
  end
  always @(posedge clk) if (baud_pulse) tick <= tick + 1;
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction
  always @(negedge clk) if (push16) begin
    np16++;
    last16 = tick;
    if (q16.size() == 0) check("ovs16 unexpected push dout", dout16, 32'hFFFF_FFFF);
    else begin
      e16 = q16.pop_front();
      check("ovs16 dout", dout16, e16.d);
      check("ovs16 pe", pe16, e16.pe);
      check("ovs16 fe", fe16, e16.fe);
      check("ovs16 bi", bi16, e16.bi);
    end
  end
  always @(negedge clk) if (push8) begin
    np8++;
    if (q8.size() == 0) check("ovs8 unexpected push dout", dout8, 32'hFFFF_FFFF);
    else begin
      e8 = q8.pop_front();
      check("ovs8 dout", dout8, e8.d);
      check("ovs8 pe", pe8, e8.pe);
      check("ovs8 fe", fe8, e8.fe);
      check("ovs8 bi", bi8, e8.bi);
    end
  end
  task automatic drv(input bit s8, input logic v, input int n);
    if (s8) rx8 = v;
    else rx16 = v;
    repeat (n) @(posedge clk iff baud_pulse);
    @(negedge clk);
  endtask
  task automatic send(input bit s8, input logic [7:0] d, input int n, input bit hp, input logic p,
                      input logic st, input int g);
    int o;
    o = s8 ? 8 : 16;
    t_start = tick;
    drv(s8, 1'b0, o);
    for (int i = 0; i < n; i++)
      if (i == g) begin
        drv(s8, d[i], o / 2);
        drv(s8, ~d[i], 1);
        drv(s8, d[i], o / 2 - 1);
      end else drv(s8, d[i], o);
    if (hp) drv(s8, p, o);
    drv(s8, st, o);
  endtask
  initial begin
    int n;
    repeat (4) @(negedge clk);
    rst = 0;
    check("reset push16", push16, 0);
    check("reset dout16", dout16, 0);
    check("reset pe/fe/bi16", {pe16, fe16, bi16}, 0);
    check("reset push8/dout8", {push8, dout8}, 0);
    drv(0, 1'b1, 4);
    q16.push_back({8'hA5, 3'b000});
    send(0, 8'hA5, 8, 0, 1'b0, 1'b1, -1);
    check("8N1 latency", last16 - t_start - 1, 153);
    drv(0, 1'b1, 4);
    wls = 2'b10; pen = 1; eps = 1;
    q16.push_back({8'h35, 3'b100});
    send(0, 8'h35, 7, 1, 1'b1, 1'b1, -1);
    drv(0, 1'b1, 4);
    wls = 2'b11; pen = 0;
    n = np16;
    drv(0, 1'b0, 4);
    drv(0, 1'b1, 24);
    check("false start push count", np16, n);
    q16.push_back({8'h00, 3'b000});
    send(0, 8'h00, 8, 0, 1'b0, 1'b1, 3);
    drv(0, 1'b1, 4);
    pen = 1; eps = 1;
    q16.push_back({8'h00, 3'b011});
    n = np16;
    drv(0, 1'b0, 528);
    check("break push count", np16 - n, 1);
    drv(0, 1'b1, 20);
    check("break release push count", np16 - n, 1);
    q16.push_back({8'h5A, 3'b000});
    send(0, 8'h5A, 8, 1, 1'b0, 1'b1, -1);
    drv(0, 1'b1, 4);
    wls = 2'b00; sticky_parity = 1; eps = 0;
    drv(1, 1'b1, 4);
    q8.push_back({8'h1F, 3'b000});
    q8.push_back({8'h0A, 3'b000});
    send(1, 8'h1F, 5, 1, 1'b1, 1'b1, -1);
    send(1, 8'h0A, 5, 1, 1'b1, 1'b1, -1);
    drv(1, 1'b1, 4);
    check("ovs8 push count", np8, 2);
    wls = 2'b11; pen = 0; sticky_parity = 0;
    q16.push_back({8'hC3, 3'b000});
    fork
      send(0, 8'hC3, 8, 0, 1'b0, 1'b1, -1);
      begin
        repeat (40) @(posedge clk iff baud_pulse);
        @(negedge clk);
        wls = 2'b00;
        pen = 1;
      end
    join
    drv(0, 1'b1, 4);
    wls = 2'b11; pen = 0;
    n = np16;
    drv(0, 1'b0, 16);
    drv(0, 1'b1, 16);
    drv(0, 1'b0, 16);
    rx16 = 1;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    check("mid-frame reset dout16", dout16, 0);
    check("mid-frame reset push/pe/fe/bi16", {push16, pe16, fe16, bi16}, 0);
    drv(0, 1'b1, 20);
    check("mid-frame reset push count", np16, n);
    q16.push_back({8'h3C, 3'b000});
    send(0, 8'h3C, 8, 0, 1'b0, 1'b1, -1);
    drv(0, 1'b1, 4);
    check("ovs16 queue drained", q16.size(), 0);
    check("ovs8 queue drained", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule
